// File: rtl/uart_mult_byte_tx.sv
// Packet UART transmitter: frames a latched payload as HEAD, payload bytes, [CRC8], TAIL, each byte 8N1 LSB first.
// Optional feature macro: UART_TX_CRC8_EN inserts a CRC-8/SMBUS byte (over payload only) ahead of TAIL.
module uart_mult_byte_tx #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD      = 115200,
  parameter int         NUM_BYTES = 11,
  parameter logic [7:0] HEAD      = 8'hA5,
  parameter logic [7:0] TAIL      = 8'h5A
) (
  input  logic                   clk_50M_o,
  input  logic                   rst_n,
  input  logic                   tx_start,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic [5:0]             byte_idx,
  output logic                   uart_txd
);

  localparam int            BIT_CNT   = CLK_FREQ / BAUD;
  localparam int            CW        = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CNT - 1);
  localparam logic [5:0]    LAST_PAY  = 6'(NUM_BYTES);
`ifdef UART_TX_CRC8_EN
  localparam logic [5:0]    LAST_IDX  = 6'(NUM_BYTES + 2);
`else
  localparam logic [5:0]    LAST_IDX  = 6'(NUM_BYTES + 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} state_t;

  state_t                 state;
  logic [CW-1:0]          baud_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_byte;
  logic [8*NUM_BYTES-1:0] shadow;
  logic                   bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_CRC8_EN
  logic [7:0] crc;
  logic       crc_fb;
  logic       pay_byte;

  // CRC-8/SMBUS consumes each byte MSB first even though the line sends LSB first.
  assign pay_byte = (byte_idx != 6'd0) && (byte_idx <= LAST_PAY);
  assign crc_fb   = crc[7] ^ tx_byte[3'd7 - bit_cnt];
`endif

  always_ff @(posedge clk_50M_o or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_byte  <= 8'h00;
      shadow   <= '0;
      byte_idx <= 6'd0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      uart_txd <= 1'b1;
`ifdef UART_TX_CRC8_EN
      crc      <= 8'h00;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (tx_start) begin
            shadow   <= tx_data;
            tx_byte  <= HEAD;
            byte_idx <= 6'd0;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            tx_busy  <= 1'b1;
            uart_txd <= 1'b0;
            state    <= START;
`ifdef UART_TX_CRC8_EN
            crc      <= 8'h00;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            uart_txd <= tx_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
`ifdef UART_TX_CRC8_EN
            if (pay_byte) crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
            if (bit_cnt == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= STOP;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_txd <= tx_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= NEXT;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        NEXT: begin
          baud_cnt <= '0;
          bit_cnt  <= 3'd0;
          if (byte_idx == LAST_IDX) begin
            byte_idx <= 6'd0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            uart_txd <= 1'b1;
            state    <= IDLE;
          end else begin
            // Payload is consumed from the bottom of the shadow register, byte 0 first.
            if (byte_idx < LAST_PAY) begin
              tx_byte <= shadow[7:0];
              shadow  <= shadow >> 8;
`ifdef UART_TX_CRC8_EN
            end else if (byte_idx == LAST_PAY) begin
              tx_byte <= crc;
`endif
            end else begin
              tx_byte <= TAIL;
            end
            byte_idx <= byte_idx + 6'd1;
            uart_txd <= 1'b0;
            state    <= START;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: random payloads checked against a frame/line model and a UART decoder.
// Works with or without UART_TX_CRC8_EN; the expected frame follows the same macro.
module tb_uart_mult_byte_tx;

  localparam int         CLK_FREQ = 50000000;
  localparam int         BAUD     = 5000000;
  localparam int         B        = CLK_FREQ / BAUD;
  localparam int         NB       = 9;
  localparam int         W        = 8 * NB;
  localparam logic [7:0] HEAD     = 8'hA5;
  localparam logic [7:0] TAIL     = 8'h5A;
`ifdef UART_TX_CRC8_EN
  localparam int         F        = NB + 3;
`else
  localparam int         F        = NB + 2;
`endif
  localparam int         SLOT     = 10 * B + 1;
  localparam int         DUR      = F * SLOT;

  logic         clk_50M_o = 1'b0;
  logic         rst_n     = 1'b0;
  logic         tx_start  = 1'b0;
  logic [W-1:0] tx_data   = '0;
  logic         tx_busy;
  logic         tx_done;
  logic [5:0]   byte_idx;
  logic         uart_txd;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] frame_m[$];
  logic [7:0] dec_q[$];
  logic       line_q[$];
  logic [5:0] idx_q[$];
  int         done_at;
  int         busy_drop;

  uart_mult_byte_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .NUM_BYTES(NB),
    .HEAD     (HEAD),
    .TAIL     (TAIL)
  ) dut (
    .clk_50M_o(clk_50M_o),
    .rst_n    (rst_n),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .byte_idx (byte_idx),
    .uart_txd (uart_txd)
  );

  always #10 clk_50M_o = ~clk_50M_o;

  // ---------------- reference model ----------------
  function automatic logic [7:0] crc8_ref(input logic [W-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < NB; k++) begin
      c = c ^ d[8*k +: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic build_model(input logic [W-1:0] d);
    frame_m.delete();
    frame_m.push_back(HEAD);
    for (int k = 0; k < NB; k++) frame_m.push_back(d[8*k +: 8]);
`ifdef UART_TX_CRC8_EN
    frame_m.push_back(crc8_ref(d));
`endif
    frame_m.push_back(TAIL);
    exp_q = frame_m;
  endtask

  // Line level in cycle c after the accepting edge: start, 8 data, stop, then one NEXT cycle per byte.
  function automatic logic exp_line(input int c);
    int         b, r, s;
    logic [7:0] v;
    b = c / SLOT;
    r = c % SLOT;
    if (r >= 10 * B) return 1'b1;
    s = r / B;
    if (s == 0) return 1'b0;
    if (s == 9) return 1'b1;
    v = frame_m[b];
    return v[s-1];
  endfunction

  function automatic int wave_errs();
    int e = 0;
    for (int c = 0; c < DUR; c++) if (line_q[c] !== exp_line(c)) e++;
    return e;
  endfunction

  function automatic int idx_errs();
    int e = 0;
    for (int c = 0; c < DUR; c++) if (idx_q[c] !== 6'(c / SLOT)) e++;
    return e;
  endfunction

  // Receiver model: find a start bit, then sample every bit in its middle.
  task automatic decode();
    int         i;
    logic [7:0] v;
    dec_q.delete();
    i = 0;
    while (i + B / 2 + 9 * B < line_q.size()) begin
      if (line_q[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = line_q[i + B / 2 + (k + 1) * B];
        dec_q.push_back(v);
        i = i + 10 * B;
      end else begin
        i++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [W-1:0] rand_payload();
    logic [W-1:0] d;
    for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  // Called at a negedge; returns at the negedge of the first start-bit cycle.
  task automatic start_frame(input logic [W-1:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk_50M_o);
    tx_start = 1'b0;
  endtask

  task automatic capture(input int ncyc, input bit poke, input logic [W-1:0] poke_d);
    line_q.delete();
    idx_q.delete();
    done_at   = -1;
    busy_drop = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk_50M_o);
      line_q.push_back(uart_txd);
      idx_q.push_back(byte_idx);
      if (tx_done === 1'b1 && done_at < 0) done_at = c;
      if (c < DUR && tx_busy !== 1'b1) busy_drop++;
      if (poke && c == DUR / 2) begin
        tx_data  = poke_d;
        tx_start = 1'b1;
      end
      if (poke && c == DUR / 2 + 1) tx_start = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M_o);
    n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    n_checks++; if (byte_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", byte_idx); end
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk_50M_o);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_hold bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] d;
    logic [9:0]   got_head, got_b1;
    int           we, ie;
    d = '0;
    d[7:0] = 8'h80;
    build_model(d);
    @(negedge clk_50M_o);
    start_frame(d);
    capture(DUR + 1, 1'b0, '0);
    for (int s = 0; s < 10; s++) begin
      got_head[s] = line_q[s * B + B / 2];
      got_b1[s]   = line_q[SLOT + s * B + B / 2];
    end
    we = wave_errs();
    ie = idx_errs();
    n_checks++; if (got_head !== 10'b1101001010) begin n_fail++; $display("FAIL head_bits got=%b exp=%b", got_head, 10'b1101001010); end
    n_checks++; if (got_b1 !== 10'b1100000000) begin n_fail++; $display("FAIL byte1_bits got=%b exp=%b", got_b1, 10'b1100000000); end
    n_checks++; if (we != 0) begin n_fail++; $display("FAIL single_wave bad_cycles=%0d exp=0", we); end
    n_checks++; if (ie != 0) begin n_fail++; $display("FAIL single_byte_idx bad_cycles=%0d exp=0", ie); end
    n_checks++; if (done_at != DUR) begin n_fail++; $display("FAIL single_done_time got=%0d exp=%0d", done_at, DUR); end
    n_checks++; if (busy_drop != 0) begin n_fail++; $display("FAIL single_busy low_cycles=%0d exp=0", busy_drop); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done got=%b exp=0", tx_busy); end
  endtask

  task automatic test_crc();
    logic [W-1:0] d;
    logic [7:0]   e;
    for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'h31 + 8'(k);
    build_model(d);
    @(negedge clk_50M_o);
    start_frame(d);
    capture(DUR + 1, 1'b0, '0);
    decode();
`ifdef UART_TX_CRC8_EN
    n_checks++; if (dec_q.size() < 12 || dec_q[10] !== 8'hF4) begin n_fail++; $display("FAIL crc_byte got=%h exp=f4", (dec_q.size() > 10) ? dec_q[10] : 8'hxx); end
    n_checks++; if (dec_q.size() < 12 || dec_q[11] !== TAIL) begin n_fail++; $display("FAIL crc_tail got=%h exp=%h", (dec_q.size() > 11) ? dec_q[11] : 8'hxx, TAIL); end
`else
    n_checks++; if (dec_q.size() < 11 || dec_q[10] !== TAIL) begin n_fail++; $display("FAIL nocrc_tail got=%h exp=%h", (dec_q.size() > 10) ? dec_q[10] : 8'hxx, TAIL); end
`endif
    n_checks++; if (dec_q.size() != F) begin n_fail++; $display("FAIL crc_frame_len got=%0d exp=%0d", dec_q.size(), F); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (dec_q.size() == 0 || dec_q[0] !== e) begin n_fail++; $display("FAIL crc_frame_byte%0d got=%h exp=%h", i, (dec_q.size() > 0) ? dec_q[0] : 8'hxx, e); end
      if (dec_q.size() > 0) void'(dec_q.pop_front());
    end
  endtask

  task automatic test_random_frames();
    logic [W-1:0] d;
    logic [7:0]   e;
    int           we, errs;
    for (int n = 0; n < 3; n++) begin
      d = rand_payload();
      build_model(d);
      repeat ($urandom_range(1, 20)) @(negedge clk_50M_o);
      start_frame(d);
      capture(DUR + 1, 1'b0, '0);
      decode();
      we = wave_errs();
      n_checks++; if (we != 0) begin n_fail++; $display("FAIL rand%0d_wave bad_cycles=%0d exp=0", n, we); end
      n_checks++; if (done_at != DUR) begin n_fail++; $display("FAIL rand%0d_done_time got=%0d exp=%0d", n, done_at, DUR); end
      errs = (dec_q.size() != exp_q.size()) ? 1 : 0;
      while (exp_q.size() > 0 && dec_q.size() > 0) begin
        e = exp_q.pop_front();
        if (dec_q.pop_front() !== e) errs++;
      end
      exp_q.delete();
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL rand%0d_bytes bad=%0d exp=0", n, errs); end
    end
  endtask

  task automatic test_ignore_midframe();
    logic [W-1:0] d;
    int           we;
    d = rand_payload();
    build_model(d);
    @(negedge clk_50M_o);
    start_frame(d);
    capture(DUR + 3, 1'b1, ~d);
    we = wave_errs();
    n_checks++; if (we != 0) begin n_fail++; $display("FAIL ignore_wave bad_cycles=%0d exp=0", we); end
    n_checks++; if (done_at != DUR) begin n_fail++; $display("FAIL ignore_done_time got=%0d exp=%0d", done_at, DUR); end
    n_checks++; if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin n_fail++; $display("FAIL ignore_no_queue busy=%b txd=%b exp busy=0 txd=1", tx_busy, uart_txd); end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] d;
    int           tgt, bad, we;
    logic         exp_v;
    d = rand_payload();
    d[8*3 +: 8] = 8'h00;
    build_model(d);
    tgt   = 4 * SLOT + B + 3 * B + B / 2;
    exp_v = exp_line(tgt);
    @(negedge clk_50M_o);
    start_frame(d);
    repeat (tgt) @(negedge clk_50M_o);
    n_checks++; if (uart_txd !== exp_v) begin n_fail++; $display("FAIL prereset_txd got=%b exp=%b", uart_txd, exp_v); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL midreset_txd got=%b exp=1", uart_txd); end
    n_checks++; if (tx_busy !== 1'b0 || byte_idx !== 6'd0) begin n_fail++; $display("FAIL midreset_state busy=%b idx=%0d exp busy=0 idx=0", tx_busy, byte_idx); end
    repeat (2) @(negedge clk_50M_o);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3 * SLOT; c++) begin
      @(negedge clk_50M_o);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL no_resume bad_cycles=%0d exp=0", bad); end
    d = rand_payload();
    build_model(d);
    start_frame(d);
    capture(DUR + 1, 1'b0, '0);
    we = wave_errs();
    n_checks++; if (we != 0 || done_at != DUR) begin n_fail++; $display("FAIL post_reset_frame bad_cycles=%0d done=%0d exp 0/%0d", we, done_at, DUR); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d1, d2;
    int           we1, we2, done1;
    logic         gap;
    d1 = rand_payload();
    d2 = rand_payload();
    build_model(d1);
    @(negedge clk_50M_o);
    start_frame(d1);
    capture(DUR + 1, 1'b0, '0);
    we1   = wave_errs();
    done1 = done_at;
    gap   = line_q[DUR];
    // Still in the tx_done cycle here: the new request must be taken.
    build_model(d2);
    start_frame(d2);
    capture(DUR + 1, 1'b0, '0);
    we2 = wave_errs();
    n_checks++; if (we1 != 0 || done1 != DUR) begin n_fail++; $display("FAIL b2b_frame1 bad_cycles=%0d done=%0d exp 0/%0d", we1, done1, DUR); end
    n_checks++; if (gap !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap got=%b exp=1", gap); end
    n_checks++; if (we2 != 0) begin n_fail++; $display("FAIL b2b_frame2_wave bad_cycles=%0d exp=0", we2); end
    n_checks++; if (done_at != DUR) begin n_fail++; $display("FAIL b2b_frame2_done got=%0d exp=%0d", done_at, DUR); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_crc();
    test_random_frames();
    test_ignore_midframe();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
